sc_edge_sequencer: RTL and testbench
====================================

# sc_edge_sequencer

Frame controller for the stochastic-computing edge-detector array. Per frame it clears the array, loads the stochastic number generators, runs the array for exactly 2^LEN_LOG2 bitstream cycles while driving the shared `sel` scaling stream, and counts the ones on one monitored array output. The result is returned through a valid/ready handshake. The block sits between the host/frame logic and the pixel array.

## Interface
Parameters:
- LEN_LOG2, 8: log2 of the bitstream length N.
- LFSR_W, 16: width of the sel LFSR.
- SEED, 16'hACE1: LFSR load value.
- TAPS, 16'hB400: Galois feedback mask.
- DRAIN_CYC, 1: array output latency in cycles (≥1).

Ports:
- clk, in, 1: single clock; all logic is posedge.
- reset, in, 1: asynchronous, active-high reset.
- start, in, 1: frame request; sampled only in IDLE.
- abort, in, 1: cancel the frame in progress.
- busy, out, 1: high in every state except IDLE.
- array_rst, out, 1: reset to the edge-detector array.
- sng_load, out, 1: one-cycle load strobe to the SNGs.
- stream_en, out, 1: bitstream advance enable.
- sel, out, 1: shared select stream for the array.
- s_mon, in, 1: monitored array output bit.
- res_valid, out, 1: result available.
- res_ready, in, 1: result consumed.
- res_count, out, LEN_LOG2+1: ones count of s_mon over the window.

## Operation
- States and transitions:
  - IDLE: on start, go to CLEAR.
  - CLEAR: lasts 1 cycle; array_rst=1; count cleared; go to LOAD.
  - LOAD: lasts 1 cycle; sng_load=1; LFSR loaded with SEED; run counter cleared; go to RUN.
  - RUN: lasts N cycles; stream_en=1; go to DRAIN.
  - DRAIN: lasts DRAIN_CYC cycles; stream_en=0; go to DONE.
  - DONE: res_valid=1; go to IDLE on res_ready.
- Count window:
  - count_en is stream_en delayed by DRAIN_CYC flops.
  - Each count_en cycle, res_count += s_mon.
  - Exactly N samples are taken.
  - Max value is N, so no overflow and no saturation.
- sel: combinational from state. It is 0 outside RUN.
- LFSR: Galois, right-shift.
  - Update: next = (lfsr>>1) ^ (lfsr[0] ? TAPS : 0).
  - Advances once per RUN cycle.
  - sel = lfsr[0].
- abort:
  - Any state except IDLE goes to IDLE next cycle.
  - stream_en and sng_load drop immediately.
  - res_valid is never asserted for that frame.
  - abort in DONE discards the result.
- start:
  - Ignored when busy.
  - start in the same cycle as the DONE handshake is ignored. The block is in IDLE on the next cycle.
  - start and abort together in IDLE: start wins.
- res_count holds a stable value from entry to DONE until the next CLEAR.

## Timing
- Reset values:
  - busy, array_rst, sng_load, stream_en, sel, res_valid = 0.
  - res_count = 0.
  - LFSR = SEED.
  - State = IDLE.
- With start high at edge t:
  - CLEAR occupies cycle t+1.
  - LOAD occupies cycle t+2.
  - RUN occupies cycles t+3 .. t+2+N.
  - DRAIN occupies cycles t+3+N .. t+2+N+DRAIN_CYC.
  - res_valid rises at cycle t+3+N+DRAIN_CYC.
- Frame latency from start to res_valid is N+DRAIN_CYC+3 cycles.
- Minimum frame period is N+DRAIN_CYC+4 cycles, given res_ready held high.
- Reset mid-frame returns to IDLE asynchronously with all outputs at reset values. No partial result is kept.

## Configuration
- SC_SEQ_SEL_LFSR_EN defined: sel comes from the LFSR as described above.
- SC_SEQ_SEL_LFSR_EN undefined:
  - LFSR is not instantiated.
  - sel = run_counter[0] during RUN, giving the deterministic sequence 0,1,0,1…
  - sel starts at 0 on the first RUN cycle.
  - All other behaviour is identical.

## Structure
- Package sc_seq_pkg holds:
  - state enum: IDLE, CLEAR, LOAD, RUN, DRAIN, DONE.
  - default SEED and TAPS constants.
  - localparam helper for count width.
- Sub-module sc_lfsr: parameterised Galois LFSR with load and advance enables. It is instantiated only under SC_SEQ_SEL_LFSR_EN.

## Test plan
Bench settings: LEN_LOG2=4 (N=16), DRAIN_CYC=1.
- s_mon tied 1, start at edge 0 → CLEAR at 1, LOAD at 2, RUN at 3..18, DRAIN at 19, res_valid at 20 with res_count=16. s_mon tied 0 → res_count=0.
- s_mon=1 only on the first and last counted cycles (4 and 19) → res_count=2. A 1 on cycle 3 or 20 is not counted.
- Macro defined, SEED=0xACE1 → sel on the first six RUN cycles is 1,0,0,0,0,1. Macro undefined → sel is 0,1,0,1,0,1.
- res_ready held low for 5 cycles in DONE → res_valid and res_count stay stable, and start pulses are ignored. res_ready=1 → IDLE on the next cycle, busy=0.
- abort on the 5th RUN cycle → IDLE next cycle, stream_en=0, no res_valid. A following start produces a full, correct frame.
- Async reset asserted mid-RUN between clock edges → all outputs 0 immediately. After release, start yields normal frame timing.

Source files
------------

// File: rtl/sc_seq_pkg.sv
// sc_seq_pkg: shared states, default LFSR constants and the count-width helper
// for the stochastic-computing edge sequencer.
package sc_seq_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, RUN, DRAIN, DONE} state_t;
  localparam logic [15:0] SC_SEQ_SEED = 16'hACE1;
  localparam logic [15:0] SC_SEQ_TAPS = 16'hB400;
  function automatic int count_w(input int len_log2);
    return len_log2 + 1;
  endfunction
endpackage

// File: rtl/sc_lfsr.sv
// sc_lfsr: Galois right-shift LFSR with load and advance enables; out is the LSB.
module sc_lfsr import sc_seq_pkg::*; #(
  parameter int W = 16,
  parameter logic [W-1:0] SEED = W'(SC_SEQ_SEED),
  parameter logic [W-1:0] TAPS = W'(SC_SEQ_TAPS)
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic adv,
  output logic out
);
  logic [W-1:0] lfsr_q, lfsr_d;
  always_comb lfsr_d = load ? SEED : adv ? ((lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0)) : lfsr_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) lfsr_q <= SEED;
    else lfsr_q <= lfsr_d;
  assign out = lfsr_q[0];
endmodule

// File: rtl/sc_edge_sequencer.sv
// sc_edge_sequencer: per-frame clear/load/run/drain controller with s_mon ones counter.
// SC_SEQ_SEL_LFSR_EN selects an LFSR-driven sel; otherwise sel alternates 0,1,0,1 in RUN.
module sc_edge_sequencer import sc_seq_pkg::*; #(
  parameter int LEN_LOG2 = 8,
  parameter int LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED = LFSR_W'(SC_SEQ_SEED),
  parameter logic [LFSR_W-1:0] TAPS = LFSR_W'(SC_SEQ_TAPS),
  parameter int DRAIN_CYC = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic array_rst,
  output logic sng_load,
  output logic stream_en,
  output logic sel,
  input  logic s_mon,
  output logic res_valid,
  input  logic res_ready,
  output logic [count_w(LEN_LOG2)-1:0] res_count
);
  localparam int CW = count_w(LEN_LOG2);
  localparam int DW = $clog2(DRAIN_CYC + 1);
  if (DRAIN_CYC < 1 || SEED == '0 || TAPS == '0) begin : g_bad_cfg
    $error("sc_edge_sequencer: DRAIN_CYC must be >= 1 and SEED/TAPS non-zero");
  end
  state_t state_q, state_d;
  logic [LEN_LOG2-1:0] run_q, run_d;
  logic [DW-1:0] drain_q, drain_d;
  logic [DRAIN_CYC-1:0] en_pipe_q, en_pipe_d;
  logic [CW-1:0] res_count_q, res_count_d;
  logic count_en;
  assign busy = state_q != IDLE;
  assign array_rst = state_q == CLEAR;
  assign sng_load = (state_q == LOAD) & ~abort;
  assign stream_en = (state_q == RUN) & ~abort;
  assign res_valid = (state_q == DONE) & ~abort;
  assign count_en = en_pipe_q[DRAIN_CYC-1];
  assign res_count = res_count_q;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = CLEAR;
      CLEAR:   state_d = LOAD;
      LOAD:    state_d = RUN;
      RUN:     if (run_q == '1) state_d = DRAIN;
      DRAIN:   if (drain_q == DW'(DRAIN_CYC - 1)) state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) state_d = IDLE;
    run_d = (state_q == RUN) ? run_q + 1'b1 : '0;
    drain_d = (state_q == DRAIN) ? drain_q + 1'b1 : '0;
    // the delay line is flushed in CLEAR so an aborted frame cannot leak samples
    en_pipe_d = (state_q == CLEAR) ? '0 : (en_pipe_q << 1) | DRAIN_CYC'(stream_en);
    res_count_d = (state_q == CLEAR) ? '0 : res_count_q + CW'(count_en & s_mon);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      run_q <= '0;
      drain_q <= '0;
      en_pipe_q <= '0;
      res_count_q <= '0;
    end else begin
      state_q <= state_d;
      run_q <= run_d;
      drain_q <= drain_d;
      en_pipe_q <= en_pipe_d;
      res_count_q <= res_count_d;
    end
`ifdef SC_SEQ_SEL_LFSR_EN
  logic lfsr_bit;
  sc_lfsr #(.W(LFSR_W), .SEED(SEED), .TAPS(TAPS)) u_lfsr (
    .clk(clk),
    .reset(reset),
    .load(sng_load),
    .adv(stream_en),
    .out(lfsr_bit)
  );
  assign sel = (state_q == RUN) & lfsr_bit;
`else
  assign sel = (state_q == RUN) & run_q[0];
`endif
endmodule

// File: tb/tb_sc_edge_sequencer.sv
// tb_sc_edge_sequencer: frame timing, count window, sel sequence, handshake, abort and
// async reset checks for sc_edge_sequencer with N=16 and one drain cycle.
module tb_sc_edge_sequencer;
  localparam int LEN_LOG2 = 4;
  localparam int N = 16;
  localparam int D = 1;
  localparam int CW = LEN_LOG2 + 1;
  localparam int CLR = 1;
  localparam int LD = 2;
  localparam int R0 = 3;
  localparam int R1 = 2 + N;
  localparam int DN = 3 + N + D;
  logic clk = 1'b0;
  logic reset, start, abort, res_ready, s_mon;
  logic busy, array_rst, sng_load, stream_en, sel, res_valid;
  logic [CW-1:0] res_count;
  int tests = 0;
  int fails = 0;
  logic sel_ref[N];
  typedef struct {
    logic [31:0] mask;
    int dl;
    int exp_cnt;
  } vec_t;
  vec_t vecs[6];
  always #5 clk = ~clk;
  sc_edge_sequencer #(.LEN_LOG2(LEN_LOG2), .DRAIN_CYC(D)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .abort(abort),
    .busy(busy),
    .array_rst(array_rst),
    .sng_load(sng_load),
    .stream_en(stream_en),
    .sel(sel),
    .s_mon(s_mon),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_count(res_count)
  );
  function automatic logic [5:0] outs();
    return {busy, array_rst, sng_load, stream_en, sel, res_valid};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask
  // samples taken on cycles R0+D .. R1+D (stream_en window shifted by the array latency)
  function automatic int ref_count(input logic [31:0] m);
    int c = 0;
    for (int k = R0 + D; k <= R1 + D; k++) c += int'(m[k]);
    return c;
  endfunction
  function automatic logic [5:0] ref_outs(input int k, input int dl);
    logic run;
    run = (k >= R0) && (k <= R1);
    return {k >= 1 && k <= DN + dl, k == CLR, k == LD, run,
            run && sel_ref[run ? k - R0 : 0], k >= DN && k <= DN + dl};
  endfunction
  task automatic run_frame(input logic [31:0] m, input int dl, input int exp_cnt, input string nm);
    @(negedge clk);
    start = 1'b1;
    abort = 1'b0;
    res_ready = 1'b0;
    s_mon = m[0];
    for (int k = 1; k <= DN + dl + 1; k++) begin
      @(negedge clk);
      chk($sformatf("%s outs c%0d", nm, k), 32'(outs()), 32'(ref_outs(k, dl)));
      if (k >= DN) chk($sformatf("%s res_count c%0d", nm, k), 32'(res_count), 32'(exp_cnt));
      start = (k == DN + dl + 1) ? 1'b0 : 1'($urandom_range(0, 1));
      s_mon = m[k];
      res_ready = (k < DN) ? 1'($urandom_range(0, 1)) : (k == DN + dl);
    end
  endtask
  initial begin
`ifdef SC_SEQ_SEL_LFSR_EN
    logic [15:0] l;
    l = 16'hACE1;
    for (int j = 0; j < N; j++) begin
      sel_ref[j] = l[0];
      l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    end
`else
    for (int j = 0; j < N; j++) sel_ref[j] = 1'(j % 2);
`endif
    vecs[0] = '{32'hFFFF_FFFF, 0, 16};
    vecs[1] = '{32'h0000_0000, 0, 0};
    vecs[2] = '{32'h0008_0010, 5, 2};
    vecs[3] = '{32'h0010_0008, 1, 0};
    vecs[4] = '{32'h0000_0FF0, 2, 8};
    vecs[5] = '{32'hAAAA_AAAA, 3, 8};
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    res_ready = 1'b0;
    s_mon = 1'b0;
    @(negedge clk);
    chk("reset outs", 32'(outs()), 32'h0);
    chk("reset res_count", 32'(res_count), 32'h0);
    reset = 1'b0;
    abort = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle abort only", 32'(outs()), 32'h0);
    end
    abort = 1'b0;
    for (int i = 0; i < 6; i++)
      run_frame(vecs[i].mask, vecs[i].dl, vecs[i].exp_cnt, $sformatf("vec%0d", i));
    // abort on the 5th RUN cycle
    @(negedge clk);
    start = 1'b1;
    s_mon = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    abort = 1'b1;
    #1;
    chk("abort same cycle", 32'(outs() & 6'b110100), 32'(6'b100000));
    @(negedge clk);
    abort = 1'b0;
    chk("abort next cycle", 32'(outs()), 32'h0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk($sformatf("post abort idle %0d", k), 32'(outs()), 32'h0);
    end
    run_frame(32'hFFFF_FFFF, 0, 16, "after_abort");
    // start and abort together in IDLE: start wins; abort in LOAD drops sng_load at once
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start beats abort", 32'(outs()), 32'(6'b110000));
    @(negedge clk);
    abort = 1'b1;
    #1;
    chk("abort in load", 32'(outs()), 32'(6'b100000));
    @(negedge clk);
    abort = 1'b0;
    chk("idle after load abort", 32'(outs()), 32'h0);
    // asynchronous reset between edges in RUN
    @(negedge clk);
    start = 1'b1;
    s_mon = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre reset counting", 32'(res_count), 32'd6);
    #2;
    reset = 1'b1;
    #1;
    chk("async reset outs", 32'(outs()), 32'h0);
    chk("async reset count", 32'(res_count), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    run_frame(32'h000F_FFF0, 1, 16, "after_reset");
    for (int i = 0; i < 6; i++) begin
      logic [31:0] m;
      int dl;
      m = $urandom;
      dl = $urandom_range(0, 4);
      run_frame(m, dl, ref_count(m), $sformatf("rand%0d", i));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
